// File: rtl/reg_dump_streamer_if.sv
// Byte-stream valid/ready link from the register dumper to its sink (normally a UART TX).
interface reg_dump_streamer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/reg_dump_streamer.sv
// Walks the register-file display port and streams one "xII:HHHHHHHH<LINE_END>" line per
// register over a valid/ready byte link.
module reg_dump_streamer #(
  parameter logic [4:0] FIRST_REG = 5'd0,
  parameter logic [4:0] LAST_REG  = 5'd31,
  parameter logic [7:0] LINE_END  = 8'h0A
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iStart,
  output logic [4:0]                  oRegSelect,
  input  logic [31:0]                 iRegData,
  reg_dump_streamer_if.master         tx,
  output logic                        oBusy,
  output logic                        oDone
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LATCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [4:0]  idx;
  logic [3:0]  cnt;
  logic [31:0] shadow;
  logic [31:0] sh;
  logic [7:0]  ch;
  logic        xfer;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  // Outputs decode straight from state so oTxValid drops the moment iRST rises.
  assign tx.valid   = (state == SEND);
  assign tx.data    = (state == SEND) ? ch : 8'h00;
  assign xfer       = tx.valid && tx.ready;
  assign oBusy      = (state != IDLE);
  assign oDone      = (state == DONE);
  assign oRegSelect = (state == IDLE) ? FIRST_REG : idx;

  // Nibble for cnt 4..11 ends up in sh[31:28], MSB nibble first.
  assign sh = shadow << {cnt - 4'd4, 2'b00};

  always_comb begin
    ch = 8'h00;
    case (cnt)
      4'd0:    ch = 8'h78;
      4'd1:    ch = hex({3'b000, idx[4]});
      4'd2:    ch = hex(idx[3:0]);
      4'd3:    ch = 8'h3A;
      4'd12:   ch = LINE_END;
      default: ch = hex(sh[31:28]);
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= IDLE;
      idx    <= 5'd0;
      cnt    <= 4'd0;
      shadow <= 32'd0;
    end else begin
      case (state)
        IDLE: if (iStart) begin
          state <= LATCH;
          idx   <= FIRST_REG;
        end
        LATCH: begin
          // Shadow copy keeps a line coherent even if the CPU rewrites the register.
          shadow <= iRegData;
          cnt    <= 4'd0;
          state  <= SEND;
        end
        SEND: if (xfer) begin
          if (cnt != 4'd12) begin
            cnt <= cnt + 4'd1;
          end else if (idx == LAST_REG) begin
            state <= DONE;
          end else begin
            idx   <= idx + 5'd1;
            state <= LATCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
